pipelined_adder: RTL and testbench
==================================

// Module: pipelined_adder
// PURPOSE
// - Parametrised, pipelined successor of the 32-bit combinational datapath adder.
// - Adds or subtracts two WIDTH-bit operands, split into STAGES carry-registered segments.
// - Produces result plus carry/overflow/zero flags behind a valid/ready handshake with backpressure.
// - Sits between operand-fetch and write-back in the processor datapath (ALU add path, PC/branch target).
// PARAMETERS
// - WIDTH   32  operand/result width; must be divisible by STAGES
// - STAGES  2   pipeline segments (1..WIDTH); latency in cycles; SEG = WIDTH/STAGES bits per segment
// PORTS
// - clk        in   1      single clock, rising edge
// - rst_n      in   1      asynchronous, active-low reset
// - in_valid   in   1      operand beat offered
// - in_ready   out  1      block accepts beat this cycle
// - op         in   1      0 = ADD (DI1+DI2), 1 = SUB (DI1-DI2)
// - DI1        in   WIDTH  operand A
// - DI2        in   WIDTH  operand B
// - out_valid  out  1      result beat valid
// - out_ready  in   1      downstream accepts result
// - DO         out  WIDTH  result (mod 2^WIDTH)
// - carry      out  1      carry out of MSB; for SUB, 1 = no borrow (A >= B unsigned)
// - ovf        out  1      signed two's-complement overflow
// - zero       out  1      DO == 0
// BEHAVIOUR
// - Reset (rst_n low, async): all stage valid bits 0, all data/carry regs 0; out_valid=0, DO=0, flags 0.
//   in_ready is 1 from the first cycle after reset release. Beats in flight at reset are discarded.
// - Transfer: in on in_valid&&in_ready; out on out_valid&&out_ready.
// - SUB: B' = ~DI2, carry-in = 1; ADD: B' = DI2, carry-in = 0.
// - Stage k (0..STAGES-1) adds segment k of A and B' plus the carry registered by stage k-1.
//   Upper, not-yet-added segments and the completed lower result bits travel with the beat.
//   Result: DO = A + B' + cin, exact, no truncation beyond WIDTH.
// - Latency: exactly STAGES cycles from accepted input to out_valid when out_ready held high.
// - Throughput: one beat per cycle with no stall.
// - Stall rule: stage k loads iff !valid[k] || stage k+1 loads (last stage: || out_ready).
//   in_ready = stage-0 load condition. Combinational ready chain; no bubbles are inserted.
// - Stalled stage holds data, flags and valid unchanged; an output beat is stable while out_valid && !out_ready.
// - Simultaneous accept and emit in a full pipeline: allowed, no loss, no duplication.
// - Flags are computed in the last stage:
//   ovf = (A[MSB]==B'[MSB]) && (DO[MSB]!=A[MSB]); zero = ~|DO; carry = carry out of the MSB segment.
// - STAGES=1: single registered stage, latency 1.
// - Wrap-around: results are modulo 2^WIDTH. Carry and ovf report the wrap; no saturation.
// - in_valid deasserted mid-stream leaves bubbles, which propagate as valid=0.
// - op and data are don't-care when in_valid=0.
// STRUCTURE
// - adder_pkg: OP_ADD=1'b0, OP_SUB=1'b1 localparams; flag index constants for future ALU use.
// - Sub-module adder_seg (params SEG, W_PASS): one pipeline stage.
//   It adds one SEG slice with registered carry, holds passthrough bits, and owns its valid/load logic.
// - Top instantiates STAGES adder_seg via generate, wiring carry, valid and load between stages.
// - Top computes the flags at the tail.
// - Compile-time check: WIDTH % STAGES == 0, else $error.
// TESTING
// - Reset: rst_n low mid-stream with 2 beats in flight -> out_valid=0, DO=0 while low.
//   Nothing is emitted after release until new input.
// - ADD: 32'hFFFF_FFFF + 32'h1 -> DO=0, carry=1, zero=1, ovf=0, out_valid exactly 2 cycles after accept.
// - SUB: 32'h8000_0000 - 32'h1 -> DO=32'h7FFF_FFFF, ovf=1, carry=1.
//   Also 5 - 7 -> DO=32'hFFFF_FFFE, carry=0.
// - Cross-segment carry: 32'h0000_FFFF + 32'h0000_0001 -> DO=32'h0001_0000 (carry crosses the stage boundary).
// - Backpressure: stream 8 random beats, out_ready low for cycles 3-6.
//   -> in_ready drops once full; all 8 results are in order, each checked against a reference model.
//   No drop or duplicate; DO stable while stalled.
// - Parameter sweep: WIDTH=8/STAGES=1, WIDTH=16/STAGES=4, WIDTH=64/STAGES=8.
//   Random ADD/SUB with back-to-back input and random out_ready -> matches model; latency == STAGES.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared constants for the pipelined datapath adder: operation encodings and
// flag bit positions for an ALU status word.
package adder_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    localparam int unsigned FLAG_CARRY = 32'd0;
    localparam int unsigned FLAG_OVF   = 32'd1;
    localparam int unsigned FLAG_ZERO  = 32'd2;
    localparam int unsigned N_FLAGS    = 32'd3;

endpackage

// File: rtl/adder_seg.sv
// One pipeline stage of the segmented adder: adds a SEG-bit slice with the carry
// registered by the previous stage and carries the rest of the beat along.
module adder_seg #(
    parameter int SEG    = 16,
    parameter int W_PASS = 96
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_valid,
    input  logic              i_load_next,
    input  logic [SEG-1:0]    i_a,
    input  logic [SEG-1:0]    i_b,
    input  logic              i_cin,
    input  logic [W_PASS-1:0] i_pass,
    output logic              o_load,
    output logic              o_valid,
    output logic [SEG-1:0]    o_sum,
    output logic              o_cout,
    output logic [W_PASS-1:0] o_pass
);

    logic              r_valid;
    logic [SEG-1:0]    r_sum;
    logic              r_cout;
    logic [W_PASS-1:0] r_pass;
    logic [SEG:0]      w_sum;

    // Slice addition and the stall rule: load when empty or when downstream moves.
    always_comb begin
        w_sum  = {1'b0, i_a} + {1'b0, i_b} + {{SEG{1'b0}}, i_cin};
        o_load = !r_valid || i_load_next;
    end

    // Stage register; a stalled stage keeps its beat untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_sum   <= {SEG{1'b0}};
            r_cout  <= 1'b0;
            r_pass  <= {W_PASS{1'b0}};
        end else if (o_load) begin
            r_valid <= i_valid;
            r_sum   <= w_sum[SEG-1:0];
            r_cout  <= w_sum[SEG];
            r_pass  <= i_pass;
        end else begin
            r_valid <= r_valid;
            r_sum   <= r_sum;
            r_cout  <= r_cout;
            r_pass  <= r_pass;
        end
    end

    assign o_valid = r_valid;
    assign o_sum   = r_sum;
    assign o_cout  = r_cout;
    assign o_pass  = r_pass;

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit add/subtract with valid/ready handshake. Beats carry
// {A, B', partial result}; each stage fills in its own result segment.
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op,
    input  logic [WIDTH-1:0] DI1,
    input  logic [WIDTH-1:0] DI2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] DO,
    output logic             carry,
    output logic             ovf,
    output logic             zero
);

    localparam int SEG = WIDTH / STAGES;
    localparam int PW  = 3 * WIDTH;

    if ((WIDTH % STAGES) != 0) begin : g_width_check
        $error("pipelined_adder: WIDTH must be divisible by STAGES");
    end

    logic [WIDTH-1:0] w_b_eff;
    logic             w_cin;
    logic [PW-1:0]    w_pass_in  [STAGES+1];
    logic [PW-1:0]    w_pass_out [STAGES];
    logic [SEG-1:0]   w_sum_seg  [STAGES];
    logic             w_valid    [STAGES+1];
    logic             w_load     [STAGES+1];
    logic             w_carry    [STAGES+1];
    logic             w_a_msb;
    logic             w_b_msb;

    // Subtraction is A + ~B + 1.
    always_comb begin
        if (op == OP_SUB) begin
            w_b_eff = ~DI2;
            w_cin   = 1'b1;
        end else begin
            w_b_eff = DI2;
            w_cin   = 1'b0;
        end
    end

    assign w_pass_in[0]   = {DI1, w_b_eff, {WIDTH{1'b0}}};
    assign w_valid[0]     = in_valid;
    assign w_carry[0]     = w_cin;
    assign w_load[STAGES] = out_ready;
    assign in_ready       = w_load[0];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [WIDTH-1:0] w_seg_pos;

        adder_seg #(
            .SEG    (SEG),
            .W_PASS (PW)
        ) u_seg (
            .clk         (clk),
            .rst_n       (rst_n),
            .i_valid     (w_valid[k]),
            .i_load_next (w_load[k+1]),
            .i_a         (w_pass_in[k][2*WIDTH + k*SEG +: SEG]),
            .i_b         (w_pass_in[k][WIDTH + k*SEG +: SEG]),
            .i_cin       (w_carry[k]),
            .i_pass      (w_pass_in[k]),
            .o_load      (w_load[k]),
            .o_valid     (w_valid[k+1]),
            .o_sum       (w_sum_seg[k]),
            .o_cout      (w_carry[k+1]),
            .o_pass      (w_pass_out[k])
        );

        // Result bits of segment k are still zero in the passthrough, so OR merges them.
        assign w_seg_pos      = WIDTH'(w_sum_seg[k]) << (k * SEG);
        assign w_pass_in[k+1] = w_pass_out[k] | {{(2*WIDTH){1'b0}}, w_seg_pos};
    end

    assign DO        = w_pass_in[STAGES][WIDTH-1:0];
    assign w_a_msb   = w_pass_in[STAGES][3*WIDTH-1];
    assign w_b_msb   = w_pass_in[STAGES][2*WIDTH-1];
    assign out_valid = w_valid[STAGES];

    // Flags are qualified by out_valid so they read 0 on an empty output.
    assign carry = out_valid & w_carry[STAGES];
    assign zero  = out_valid & ~|DO;
    assign ovf   = out_valid & (w_a_msb == w_b_msb) & (DO[WIDTH-1] != w_a_msb);

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder: directed corner cases on the default
// 32/2 build plus a randomized sweep over 8/1, 16/4 and 64/8 builds.
`timescale 1ns/1ps
module tb_pipelined_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [3:0]  in_valid, op, out_ready;
    logic [63:0] di1 [4];
    logic [63:0] di2 [4];
    wire  [3:0]  irdy, ovld, cy, ov, zr;
    wire  [31:0] do0;
    wire  [7:0]  do1;
    wire  [15:0] do2;
    wire  [63:0] do3;

    pipelined_adder #(.WIDTH(32), .STAGES(2)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(irdy[0]), .op(op[0]),
        .DI1(di1[0][31:0]), .DI2(di2[0][31:0]), .out_valid(ovld[0]), .out_ready(out_ready[0]),
        .DO(do0), .carry(cy[0]), .ovf(ov[0]), .zero(zr[0]));
    pipelined_adder #(.WIDTH(8), .STAGES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(irdy[1]), .op(op[1]),
        .DI1(di1[1][7:0]), .DI2(di2[1][7:0]), .out_valid(ovld[1]), .out_ready(out_ready[1]),
        .DO(do1), .carry(cy[1]), .ovf(ov[1]), .zero(zr[1]));
    pipelined_adder #(.WIDTH(16), .STAGES(4)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(irdy[2]), .op(op[2]),
        .DI1(di1[2][15:0]), .DI2(di2[2][15:0]), .out_valid(ovld[2]), .out_ready(out_ready[2]),
        .DO(do2), .carry(cy[2]), .ovf(ov[2]), .zero(zr[2]));
    pipelined_adder #(.WIDTH(64), .STAGES(8)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[3]), .in_ready(irdy[3]), .op(op[3]),
        .DI1(di1[3]), .DI2(di2[3]), .out_valid(ovld[3]), .out_ready(out_ready[3]),
        .DO(do3), .carry(cy[3]), .ovf(ov[3]), .zero(zr[3]));

    typedef struct {
        logic [63:0] d;
        logic        c;
        logic        v;
        logic        z;
        int          t;
    } exp_t;

    exp_t        q [4][$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    logic [3:0]  acc, got, lat_chk, held_v;
    logic [63:0] held_do [4];
    logic [63:0] act_do [4];
    logic [3:0]  act_c, act_v, act_z;
    int          act_lat [4];

    function automatic int wid(input int j);
        case (j)
            0:       return 32;
            1:       return 8;
            2:       return 16;
            default: return 64;
        endcase
    endfunction

    function automatic int stg(input int j);
        case (j)
            0:       return 2;
            1:       return 1;
            2:       return 4;
            default: return 8;
        endcase
    endfunction

    function automatic logic [63:0] get_do(input int j);
        case (j)
            0:       return {32'd0, do0};
            1:       return {56'd0, do1};
            2:       return {48'd0, do2};
            default: return do3;
        endcase
    endfunction

    // Reference: exact integer arithmetic on unsigned and signed interpretations.
    function automatic exp_t ref_model(input int w, input logic sub,
                                       input logic [63:0] a, input logic [63:0] b);
        exp_t r;
        logic [65:0] pw, ua, ub, s;
        logic signed [67:0] sa, sb, ex, hf;
        pw = 66'd1 << w;
        ua = {2'b00, a} & (pw - 66'd1);
        ub = {2'b00, b} & (pw - 66'd1);
        if (sub) begin
            s   = ua + pw - ub;
            r.c = (ua >= ub);
        end else begin
            s   = ua + ub;
            r.c = (s >= pw);
        end
        s   = s & (pw - 66'd1);
        r.d = s[63:0];
        r.z = (r.d == 64'd0);
        sa = {2'b00, ua};
        if (ua[w-1]) sa = sa - {2'b00, pw};
        sb = {2'b00, ub};
        if (ub[w-1]) sb = sb - {2'b00, pw};
        ex  = sub ? (sa - sb) : (sa + sb);
        hf  = {2'b00, pw >> 1};
        r.v = (ex >= hf) || (ex < -hf);
        r.t = 0;
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: at the falling edge score accepts/emits of every DUT, then return just after the rising edge.
    task automatic tick();
        @(negedge clk);
        cyc++;
        acc = 4'b0000;
        got = 4'b0000;
        for (int j = 0; j < 4; j++) begin
            if (held_v[j]) begin
                check($sformatf("hold_valid[%0d]", j), {63'd0, ovld[j]}, 64'd1);
                check($sformatf("hold_do[%0d]", j), get_do(j), held_do[j]);
            end
            held_v[j]  = ovld[j] && !out_ready[j];
            held_do[j] = get_do(j);
            if (in_valid[j] && irdy[j]) begin
                exp_t e;
                e   = ref_model(wid(j), op[j], di1[j], di2[j]);
                e.t = cyc;
                q[j].push_back(e);
                acc[j] = 1'b1;
            end
            if (ovld[j] && out_ready[j]) begin
                if (q[j].size() == 0) begin
                    check($sformatf("spurious[%0d]", j), {63'd0, ovld[j]}, 64'd0);
                end else begin
                    exp_t e;
                    e = q[j].pop_front();
                    check($sformatf("do[%0d]", j), get_do(j), e.d);
                    check($sformatf("carry[%0d]", j), {63'd0, cy[j]}, {63'd0, e.c});
                    check($sformatf("ovf[%0d]", j), {63'd0, ov[j]}, {63'd0, e.v});
                    check($sformatf("zero[%0d]", j), {63'd0, zr[j]}, {63'd0, e.z});
                    act_do[j]  = get_do(j);
                    act_c[j]   = cy[j];
                    act_v[j]   = ov[j];
                    act_z[j]   = zr[j];
                    act_lat[j] = cyc - e.t;
                    if (lat_chk[j]) check($sformatf("latency[%0d]", j), 64'(cyc - e.t), 64'(stg(j)));
                    got[j] = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int j, input logic sub, input logic [63:0] a, input logic [63:0] b);
        in_valid[j] = 1'b1;
        op[j]       = sub;
        di1[j]      = a;
        di2[j]      = b;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (acc[j]) break;
        end
        check("send_accept", {63'd0, acc[j]}, 64'd1);
        in_valid[j] = 1'b0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (got[j]) break;
        end
        check("send_emit", {63'd0, got[j]}, 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   sent, rcv;
        logic saw_block;
        rst_n     = 1'b0;
        in_valid  = 4'b0000;
        op        = 4'b0000;
        out_ready = 4'b1111;
        lat_chk   = 4'b1111;
        held_v    = 4'b0000;
        for (int j = 0; j < 4; j++) begin
            di1[j] = 64'd0;
            di2[j] = 64'd0;
        end
        repeat (3) tick();
        check("rst_out_valid", {60'd0, ovld}, 64'd0);
        check("rst_do", get_do(0), 64'd0);
        check("rst_flags", {52'd0, cy, ov, zr}, 64'd0);
        rst_n = 1'b1;
        tick();
        check("in_ready_after_rst", {60'd0, irdy}, 64'hF);

        send(0, 1'b0, 64'hFFFF_FFFF, 64'h1);
        check("add_wrap_do", act_do[0], 64'd0);
        check("add_wrap_flags", {61'd0, act_c[0], act_z[0], act_v[0]}, 64'b110);
        check("add_wrap_lat", 64'(act_lat[0]), 64'd2);

        send(0, 1'b1, 64'h8000_0000, 64'h1);
        check("sub_ovf_do", act_do[0], 64'h7FFF_FFFF);
        check("sub_ovf_flags", {62'd0, act_v[0], act_c[0]}, 64'b11);

        send(0, 1'b1, 64'd5, 64'd7);
        check("sub_borrow_do", act_do[0], 64'hFFFF_FFFE);
        check("sub_borrow_carry", {63'd0, act_c[0]}, 64'd0);

        send(0, 1'b0, 64'h0000_FFFF, 64'h0000_0001);
        check("cross_seg_do", act_do[0], 64'h0001_0000);

        // Reset with two beats in flight.
        out_ready[0] = 1'b0;
        in_valid[0]  = 1'b1;
        di1[0] = {32'd0, $urandom};
        di2[0] = {32'd0, $urandom};
        tick();
        di1[0] = {32'd0, $urandom};
        tick();
        in_valid[0] = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", {63'd0, ovld[0]}, 64'd0);
        check("midrst_do", get_do(0), 64'd0);
        q[0].delete();
        held_v = 4'b0000;
        tick();
        check("midrst_hold_valid", {63'd0, ovld[0]}, 64'd0);
        rst_n        = 1'b1;
        out_ready[0] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("post_rst_idle", {63'd0, ovld[0]}, 64'd0);
        end

        // Backpressure: 8 random beats, out_ready low in cycles 3..6.
        lat_chk[0] = 1'b0;
        sent = 0;
        rcv = 0;
        saw_block = 1'b0;
        for (int c = 0; c < 60 && rcv < 8; c++) begin
            out_ready[0] = !(c >= 3 && c <= 6);
            in_valid[0]  = (sent < 8);
            op[0]        = 1'($urandom_range(0, 1));
            di1[0]       = {32'd0, $urandom};
            di2[0]       = {32'd0, $urandom};
            #1;
            if (!irdy[0]) saw_block = 1'b1;
            tick();
            if (acc[0]) sent++;
            if (got[0]) rcv++;
        end
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b1;
        check("bp_in_ready_dropped", {63'd0, saw_block}, 64'd1);
        check("bp_received", 64'(rcv), 64'd8);
        check("bp_queue_empty", 64'(q[0].size()), 64'd0);

        // Sweep phase A: back-to-back input, no stall, exact latency.
        lat_chk = 4'b1111;
        for (int k = 0; k < 12; k++) begin
            for (int j = 0; j < 4; j++) begin
                in_valid[j] = (k < 10);
                op[j]       = 1'($urandom_range(0, 1));
                di1[j]      = {$urandom, $urandom};
                di2[j]      = {$urandom, $urandom};
            end
            tick();
        end
        in_valid = 4'b0000;
        repeat (10) tick();

        // Sweep phase B: random bubbles and random backpressure.
        lat_chk = 4'b0000;
        for (int k = 0; k < 80; k++) begin
            for (int j = 0; j < 4; j++) begin
                in_valid[j]  = ($urandom_range(0, 3) != 0);
                out_ready[j] = ($urandom_range(0, 2) != 0);
                op[j]        = 1'($urandom_range(0, 1));
                di1[j]       = {$urandom, $urandom};
                di2[j]       = {$urandom, $urandom};
            end
            tick();
        end
        in_valid  = 4'b0000;
        out_ready = 4'b1111;
        repeat (12) tick();
        for (int j = 0; j < 4; j++) begin
            check($sformatf("sweep_drained[%0d]", j), 64'(q[j].size()), 64'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
